// File: rtl/mem_req_sequencer.sv
// Memory request sequencer: turns single CPU ops into registered mem_sys bus traffic.
// Optional feature macro ALLOC_ZERO_FILL_EN: zero-fill freshly allocated arrays before responding.
package mem_req_sequencer_pkg;
  localparam int unsigned BUS_W = 32;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'b00,
    OP_STORE   = 2'b01,
    OP_ALLOC   = 2'b10,
    OP_SETZERO = 2'b11
  } mem_op_e;

  typedef struct packed {
    logic [BUS_W-1:0] address;
    logic [BUS_W-1:0] offset;
    logic [BUS_W-1:0] data;
    logic [1:0]       mode;
  } mem_in_bus_t;
endpackage

module mem_req_sequencer
  import mem_req_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W    = BUS_W,
  parameter int unsigned ALLOC_MAX = 2**25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_offset,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output mem_in_bus_t       mem_bus,
  output logic              bus_en,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam logic [DATA_W-1:0] ALLOC_MAX_W = DATA_W'(ALLOC_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPT,
    S_FILL,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  mem_op_e           op_q, op_d;
  logic [DATA_W-1:0] size_q, size_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              bus_en_q, bus_en_d;
  mem_in_bus_t       bus_q, bus_d;
`ifdef ALLOC_ZERO_FILL_EN
  logic [DATA_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
`endif

  // Every output is the registered image of the value computed for the next state.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    size_d      = size_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    bus_en_d    = 1'b0;
    bus_d       = '0;
`ifdef ALLOC_ZERO_FILL_EN
    base_d      = base_q;
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d    = mem_op_e'(req_op);
          size_d  = req_offset;
          state_d = S_ISSUE;
          // Oversized ALLOC still spends the ISSUE cycle, but keeps the bus quiet.
          if (!(mem_op_e'(req_op) == OP_ALLOC && req_offset > ALLOC_MAX_W)) begin
            bus_en_d        = 1'b1;
            bus_d.address   = req_addr;
            bus_d.offset    = req_offset;
            bus_d.data      = (mem_op_e'(req_op) == OP_SETZERO) ? req_addr : req_data;
            bus_d.mode      = req_op;
          end
        end
      end
      S_ISSUE: begin
        case (op_q)
          OP_LOAD: state_d = S_CAPT;
          OP_ALLOC: begin
            if (size_q > ALLOC_MAX_W) begin
              state_d    = S_RESP;
              rsp_data_d = '0;
              rsp_err_d  = 1'b1;
            end else begin
              state_d = S_CAPT;
            end
          end
          default: begin
            state_d    = S_RESP;
            rsp_data_d = '0;
            rsp_err_d  = 1'b0;
          end
        endcase
      end
      S_CAPT: begin
        state_d    = S_RESP;
        rsp_data_d = mem_data_out;
        // A zero base would alias the zero array.
        rsp_err_d  = (op_q == OP_ALLOC) && (mem_data_out == '0);
`ifdef ALLOC_ZERO_FILL_EN
        if (op_q == OP_ALLOC && mem_data_out != '0 && size_q != '0) begin
          state_d       = S_FILL;
          rsp_data_d    = rsp_data_q;
          rsp_err_d     = rsp_err_q;
          base_d        = mem_data_out;
          cnt_d         = '0;
          bus_en_d      = 1'b1;
          bus_d.address = mem_data_out;
          bus_d.offset  = '0;
          bus_d.mode    = OP_STORE;
        end
`endif
      end
`ifdef ALLOC_ZERO_FILL_EN
      S_FILL: begin
        if (cnt_q == size_q - DATA_W'(1)) begin
          state_d    = S_RESP;
          rsp_data_d = base_q;
          rsp_err_d  = 1'b0;
        end else begin
          cnt_d         = cnt_q + DATA_W'(1);
          bus_en_d      = 1'b1;
          bus_d.address = base_q;
          bus_d.offset  = cnt_d;
          bus_d.mode    = OP_STORE;
        end
      end
`endif
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LOAD;
      size_q      <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      bus_en_q    <= 1'b0;
      bus_q       <= '0;
`ifdef ALLOC_ZERO_FILL_EN
      base_q      <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      size_q      <= size_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      bus_en_q    <= bus_en_d;
      bus_q       <= bus_d;
`ifdef ALLOC_ZERO_FILL_EN
      base_q      <= base_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign bus_en    = bus_en_q;
  assign mem_bus   = bus_q;

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Directed bench for mem_req_sequencer with a behavioural mem_sys model behind the bus.
// Expectations follow ALLOC_ZERO_FILL_EN the same way the design does.
module tb_mem_req_sequencer;
  import mem_req_sequencer_pkg::*;

`ifdef ALLOC_ZERO_FILL_EN
  localparam int ALLOC4_LAT = 7;
  localparam int ALLOC4_BUS = 5;
`else
  localparam int ALLOC4_LAT = 3;
  localparam int ALLOC4_BUS = 1;
`endif
  localparam logic [31:0] ALLOC_MAX = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr, req_offset, req_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  mem_in_bus_t mem_bus;
  logic        bus_en;
  logic [31:0] mem_data_out = '0;

  int checks = 0;
  int failures = 0;

  mem_in_bus_t busq[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] zero_base = '0;
  logic [31:0] alloc_ret;

  mem_req_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_offset(req_offset), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_bus(mem_bus), .bus_en(bus_en), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // mem_sys model: bus captured on the edge, data_out registered one edge later.
  always @(posedge clk) begin
    if (bus_en) begin
      busq.push_back(mem_bus);
      case (mem_bus.mode)
        2'b00: mem_data_out <= rd(((mem_bus.address == 32'h0) ? zero_base : mem_bus.address) + mem_bus.offset);
        2'b01: mem[mem_bus.address + mem_bus.offset] = mem_bus.data;
        2'b10: mem_data_out <= alloc_ret;
        default: zero_base <= mem_bus.data;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input int i, input logic [31:0] a, input logic [31:0] o,
                         input logic [31:0] d, input logic [1:0] m);
    mem_in_bus_t b;
    b = '0;
    if (i < busq.size()) b = busq[i];
    chk("bus_addr", b.address, a);
    chk("bus_off", b.offset, o);
    chk("bus_data", b.data, d);
    chk("bus_mode", 32'(b.mode), 32'(m));
  endtask

  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] o,
                        input logic [31:0] d, output int lat, output logic [31:0] rdat,
                        output logic er);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    req_valid = 1'b1; req_op = op; req_addr = a; req_offset = o; req_data = d;
    busq.delete();
    tick();
    req_valid = 1'b0;
    chk("busy_not_ready", 32'(req_ready), 32'h0);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    rdat = rsp_data;
    er   = rsp_err;
    tick();
    chk("rsp_pulse_end", 32'(rsp_valid), 32'h0);
    chk("ready_after_resp", 32'(req_ready), 32'h1);
  endtask

  initial begin
    int          lat, n;
    logic [31:0] rdat;
    logic        er;
    reset = 1'b0; req_valid = 1'b0; req_op = 2'b00;
    req_addr = '0; req_offset = '0; req_data = '0; alloc_ret = '0;
    repeat (3) tick();
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_bus_en", 32'(bus_en), 32'h0);
    chk("rst_bus_mode", 32'(mem_bus.mode), 32'h0);
    chk("rst_bus_addr", mem_bus.address, 32'h0);
    reset = 1'b1;
    tick();

    // Seed 0x103 then LOAD it back.
    do_req(2'b01, 32'h100, 32'h3, 32'hDEAD_BEEF, lat, rdat, er);
    chk("st0_lat", 32'(lat), 32'd2);
    chk("st0_data", rdat, 32'h0);
    do_req(2'b00, 32'h100, 32'h3, 32'h0, lat, rdat, er);
    chk("ld0_lat", 32'(lat), 32'd3);
    chk("ld0_data", rdat, 32'hDEAD_BEEF);
    chk("ld0_err", 32'(er), 32'h0);
    chk("ld0_bus_cnt", 32'(busq.size()), 32'd1);
    chk_bus(0, 32'h100, 32'h3, 32'h0, 2'b00);

    do_req(2'b01, 32'h200, 32'h1, 32'h55, lat, rdat, er);
    chk("st1_lat", 32'(lat), 32'd2);
    chk("st1_data", rdat, 32'h0);
    chk("st1_bus_cnt", 32'(busq.size()), 32'd1);
    chk_bus(0, 32'h200, 32'h1, 32'h55, 2'b01);
    do_req(2'b00, 32'h200, 32'h1, 32'h0, lat, rdat, er);
    chk("ld1_data", rdat, 32'h55);

    alloc_ret = 32'h1000;
    do_req(2'b10, 32'h0, 32'h4, 32'h0, lat, rdat, er);
    chk("al4_lat", 32'(lat), 32'(ALLOC4_LAT));
    chk("al4_data", rdat, 32'h1000);
    chk("al4_err", 32'(er), 32'h0);
    chk("al4_bus_cnt", 32'(busq.size()), 32'(ALLOC4_BUS));
    chk("al4_bus_mode", 32'(busq.size() > 0 ? busq[0].mode : 2'b00), 32'h2);
    chk("al4_bus_size", busq.size() > 0 ? busq[0].offset : 32'h0, 32'h4);
    for (int i = 1; i < ALLOC4_BUS; i++) chk_bus(i, 32'h1000, 32'(i - 1), 32'h0, 2'b01);

    do_req(2'b10, 32'h0, ALLOC_MAX + 32'h1, 32'h0, lat, rdat, er);
    chk("alBig_lat", 32'(lat), 32'd2);
    chk("alBig_err", 32'(er), 32'h1);
    chk("alBig_bus_cnt", 32'(busq.size()), 32'd0);

    alloc_ret = 32'h0;
    do_req(2'b10, 32'h0, 32'h2, 32'h0, lat, rdat, er);
    chk("alZero_lat", 32'(lat), 32'd3);
    chk("alZero_err", 32'(er), 32'h1);

    do_req(2'b01, 32'h4000, 32'h2, 32'hCAFE_0002, lat, rdat, er);
    do_req(2'b11, 32'h4000, 32'h0, 32'h0, lat, rdat, er);
    chk("sz_lat", 32'(lat), 32'd2);
    chk("sz_data", rdat, 32'h0);
    chk("sz_err", 32'(er), 32'h0);
    chk("sz_bus_cnt", 32'(busq.size()), 32'd1);
    chk_bus(0, 32'h4000, 32'h0, 32'h4000, 2'b11);
    do_req(2'b00, 32'h0, 32'h2, 32'h0, lat, rdat, er);
    chk("ldz_data", rdat, 32'hCAFE_0002);

    // Abort an op in flight with reset.
    busq.delete();
`ifdef ALLOC_ZERO_FILL_EN
    alloc_ret = 32'h2000;
    req_valid = 1'b1; req_op = 2'b10; req_addr = '0; req_offset = 32'h8; req_data = '0;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (busq.size() < 4 && n < 30) begin
      tick();
      n++;
    end
    chk("abort_words_seen", 32'(busq.size()), 32'd4);
`else
    req_valid = 1'b1; req_op = 2'b00; req_addr = 32'h100; req_offset = 32'h3; req_data = '0;
    tick();
    req_valid = 1'b0;
`endif
    reset = 1'b0;
    tick();
    chk("abort_bus_en", 32'(bus_en), 32'h0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("abort_ready", 32'(req_ready), 32'h1);
    chk("abort_bus_mode", 32'(mem_bus.mode), 32'h0);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid) n++;
    end
    chk("abort_no_rsp", 32'(n), 32'd0);

    do_req(2'b00, 32'h100, 32'h3, 32'h0, lat, rdat, er);
    chk("recover_lat", 32'(lat), 32'd3);
    chk("recover_data", rdat, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
